// File: rtl/pipe_pkg.sv
// Shared EX->MEM bundle type and helpers for the elastic pipeline stages.
package pipe_pkg;

    // Bundle field widths; em_stage_elastic's XLEN/RD_W must match these.
    localparam int PIPE_XLEN = 32;
    localparam int PIPE_RD_W = 5;

    localparam logic [1:0] MST_NONE = 2'd0;
    localparam logic [2:0] MLD_NONE = 3'd0;

    typedef struct packed {
        logic [PIPE_XLEN-1:0] pc;
        logic [PIPE_XLEN-1:0] inst;
        logic [PIPE_RD_W-1:0] rd;
        logic [PIPE_XLEN-1:0] result;
        logic [PIPE_XLEN-1:0] store_data;
        logic [1:0]           mem_store;
        logic [2:0]           mem_load;
        logic                 reg_write;
    } em_bundle_t;

    // View of a held bundle as MEM sees it: a bubble never carries side-effect
    // controls, and optionally carries no payload at all.
    function automatic em_bundle_t em_gate(input em_bundle_t b, input logic vld,
                                           input logic zero_bub);
        em_bundle_t g;
        g = b;
        if (!vld) begin
            if (zero_bub) begin
                g = '0;
            end
            g.mem_store = MST_NONE;
            g.mem_load  = MLD_NONE;
            g.reg_write = 1'b0;
        end
        return g;
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One pipeline entry: valid bit plus em_bundle_t payload with load/kill/wipe controls.
module pipe_skid_slot
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       nrst,
    input  logic       load,
    input  logic       kill,
    input  logic       wipe,
    input  em_bundle_t d,
    output logic       valid,
    output em_bundle_t q
);

    logic       valid_q;
    logic       valid_d;
    em_bundle_t payload_q;
    em_bundle_t payload_d;

    // Next state: a load always wins; otherwise kill drops the entry and wipe zeroes its payload.
    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        if (load) begin
            valid_d   = 1'b1;
            payload_d = d;
        end else begin
            if (kill) begin
                valid_d = 1'b0;
            end
            if (wipe) begin
                payload_d = '0;
            end
        end
    end

    // Entry register, synchronous active-low reset clears valid and payload.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

    assign valid = valid_q;
    assign q     = payload_q;

endmodule

// File: rtl/em_stage_elastic.sv
// Elastic EX->MEM stage: main entry plus optional skid entry, flush, occupancy and forwarding taps.
module em_stage_elastic
    import pipe_pkg::*;
#(
    parameter int XLEN     = PIPE_XLEN,
    parameter int RD_W     = PIPE_RD_W,
    parameter int SKID     = 1,
    parameter int ZERO_BUB = 1
) (
    input  logic            CLK,
    input  logic            NRST,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pcE,
    input  logic [XLEN-1:0] instE,
    input  logic [RD_W-1:0] rdE,
    input  logic [XLEN-1:0] resultE,
    input  logic [XLEN-1:0] store_dataE,
    input  logic [1:0]      mem_storeE,
    input  logic [2:0]      mem_loadE,
    input  logic            reg_writeE,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] pcM,
    output logic [XLEN-1:0] instM,
    output logic [RD_W-1:0] rdM,
    output logic [XLEN-1:0] resultM,
    output logic [XLEN-1:0] store_dataM,
    output logic [1:0]      mem_storeM,
    output logic [2:0]      mem_loadM,
    output logic            reg_writeM,
    output logic [RD_W-1:0] fwd_rd0,
    output logic [RD_W-1:0] fwd_rd1,
    output logic            fwd_we0,
    output logic            fwd_we1,
    output logic [1:0]      occ
);

    em_bundle_t in_b;
    em_bundle_t main_b;
    em_bundle_t skid_b;
    em_bundle_t main_din;
    em_bundle_t head_b;
    logic       main_vld;
    logic       skid_vld;
    logic       accept;
    logic       consume;
    logic       main_load;
    logic       main_kill;
    logic       main_wipe;
    logic       skid_load;
    logic       skid_kill;
    logic       skid_wipe;

    assign in_b = '{pc: pcE, inst: instE, rd: rdE, result: resultE, store_data: store_dataE,
                    mem_store: mem_storeE, mem_load: mem_loadE, reg_write: reg_writeE};

    // With a skid entry, in_ready comes straight from a flop; without one it is combinational.
    assign in_ready = (SKID != 0) ? !skid_vld : (!main_vld || out_ready);

    // Handshake control: decide which entries load, drop, or are wiped this cycle.
    always_comb begin
        accept    = in_valid && in_ready;
        consume   = main_vld && out_ready;
        main_din  = skid_vld ? skid_b : in_b;
        main_load = 1'b0;
        main_kill = 1'b0;
        skid_load = 1'b0;
        skid_kill = 1'b0;
        if (flush) begin
            // Flush discards everything, including a same-cycle accept.
            main_kill = 1'b1;
            skid_kill = 1'b1;
        end else if (SKID != 0) begin
            // The skid entry is always older than the input, so it refills main first.
            if (skid_vld) begin
                main_load = consume;
            end else begin
                main_load = accept && (!main_vld || consume);
            end
            main_kill = consume && !main_load;
            skid_load = accept && main_vld && !consume;
            skid_kill = skid_vld && consume;
        end else begin
            main_load = accept;
            main_kill = consume && !accept;
        end
        main_wipe = (ZERO_BUB != 0) && main_kill;
        skid_wipe = (ZERO_BUB != 0) && skid_kill;
    end

    pipe_skid_slot u_main (
        .clk   (CLK),
        .nrst  (NRST),
        .load  (main_load),
        .kill  (main_kill),
        .wipe  (main_wipe),
        .d     (main_din),
        .valid (main_vld),
        .q     (main_b)
    );

    pipe_skid_slot u_skid (
        .clk   (CLK),
        .nrst  (NRST),
        .load  (skid_load),
        .kill  (skid_kill),
        .wipe  (skid_wipe),
        .d     (in_b),
        .valid (skid_vld),
        .q     (skid_b)
    );

    assign head_b      = em_gate(main_b, main_vld, ZERO_BUB != 0);
    assign out_valid   = main_vld;
    assign pcM         = head_b.pc;
    assign instM       = head_b.inst;
    assign rdM         = head_b.rd;
    assign resultM     = head_b.result;
    assign store_dataM = head_b.store_data;
    assign mem_storeM  = head_b.mem_store;
    assign mem_loadM   = head_b.mem_load;
    assign reg_writeM  = head_b.reg_write;

    assign fwd_rd0 = main_b.rd;
    assign fwd_rd1 = skid_b.rd;
    assign fwd_we0 = main_vld && main_b.reg_write;
    assign fwd_we1 = skid_vld && skid_b.reg_write;
    assign occ     = {1'b0, main_vld} + {1'b0, skid_vld};

    // Occupancy sanity: never above two, and the skid entry is only ever held behind main.
    always_ff @(posedge CLK) begin
        if (NRST) begin
            assert (occ <= 2'd2 && (main_vld || !skid_vld));
        end
    end

endmodule

// File: tb/tb_em_stage_elastic.sv
// Bench for em_stage_elastic: SKID=1 and SKID=0 instances against queue reference models.
module tb_em_stage_elastic;
    import pipe_pkg::*;

    localparam int XLEN = 32;
    localparam int RD_W = 5;

    logic CLK = 1'b0;
    logic NRST, flush, in_valid, out_ready;
    logic [XLEN-1:0] pcE, instE, resultE, store_dataE;
    logic [RD_W-1:0] rdE;
    logic [1:0]      mem_storeE;
    logic [2:0]      mem_loadE;
    logic            reg_writeE;

    logic            a_in_ready, a_out_valid, a_reg_writeM, a_fwd_we0, a_fwd_we1;
    logic [XLEN-1:0] a_pcM, a_instM, a_resultM, a_store_dataM;
    logic [RD_W-1:0] a_rdM, a_fwd_rd0, a_fwd_rd1;
    logic [1:0]      a_mem_storeM, a_occ;
    logic [2:0]      a_mem_loadM;

    logic            b_in_ready, b_out_valid, b_reg_writeM, b_fwd_we0, b_fwd_we1;
    logic [XLEN-1:0] b_pcM, b_instM, b_resultM, b_store_dataM;
    logic [RD_W-1:0] b_rdM, b_fwd_rd0, b_fwd_rd1;
    logic [1:0]      b_mem_storeM, b_occ;
    logic [2:0]      b_mem_loadM;

    em_bundle_t a_hd, b_hd;
    assign a_hd = {a_pcM, a_instM, a_rdM, a_resultM, a_store_dataM, a_mem_storeM, a_mem_loadM, a_reg_writeM};
    assign b_hd = {b_pcM, b_instM, b_rdM, b_resultM, b_store_dataM, b_mem_storeM, b_mem_loadM, b_reg_writeM};

    em_bundle_t qa[$];
    em_bundle_t qb[$];
    int ncmp = 0;
    int nfail = 0;

    always #5 CLK = ~CLK;

    em_stage_elastic #(.XLEN(XLEN), .RD_W(RD_W), .SKID(1), .ZERO_BUB(1)) dut_a (
        .CLK(CLK), .NRST(NRST), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .pcE(pcE), .instE(instE), .rdE(rdE), .resultE(resultE), .store_dataE(store_dataE),
        .mem_storeE(mem_storeE), .mem_loadE(mem_loadE), .reg_writeE(reg_writeE),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .pcM(a_pcM), .instM(a_instM), .rdM(a_rdM), .resultM(a_resultM), .store_dataM(a_store_dataM),
        .mem_storeM(a_mem_storeM), .mem_loadM(a_mem_loadM), .reg_writeM(a_reg_writeM),
        .fwd_rd0(a_fwd_rd0), .fwd_rd1(a_fwd_rd1), .fwd_we0(a_fwd_we0), .fwd_we1(a_fwd_we1), .occ(a_occ)
    );

    em_stage_elastic #(.XLEN(XLEN), .RD_W(RD_W), .SKID(0), .ZERO_BUB(1)) dut_b (
        .CLK(CLK), .NRST(NRST), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .pcE(pcE), .instE(instE), .rdE(rdE), .resultE(resultE), .store_dataE(store_dataE),
        .mem_storeE(mem_storeE), .mem_loadE(mem_loadE), .reg_writeE(reg_writeE),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .pcM(b_pcM), .instM(b_instM), .rdM(b_rdM), .resultM(b_resultM), .store_dataM(b_store_dataM),
        .mem_storeM(b_mem_storeM), .mem_loadM(b_mem_loadM), .reg_writeM(b_reg_writeM),
        .fwd_rd0(b_fwd_rd0), .fwd_rd1(b_fwd_rd1), .fwd_we0(b_fwd_we0), .fwd_we1(b_fwd_we1), .occ(b_occ)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Compare one instance against its queue model: capacity 2 (registered ready) or 1 (pass-through ready).
    task automatic chk_inst(input string nm, input bit skid, input em_bundle_t q[$],
                            input logic rdy, input logic vld, input em_bundle_t hd,
                            input logic [RD_W-1:0] r0, input logic [RD_W-1:0] r1,
                            input logic w0, input logic w1, input logic [1:0] oc);
        em_bundle_t eh;
        bit erdy;
        erdy = skid ? (q.size() < 2) : (q.size() == 0 || out_ready);
        eh = (q.size() > 0) ? q[0] : '0;
        chk({nm, ".in_ready"},    32'(rdy), 32'(erdy));
        chk({nm, ".out_valid"},   32'(vld), 32'(q.size() > 0));
        chk({nm, ".occ"},         32'(oc), 32'(q.size()));
        chk({nm, ".pcM"},         hd.pc, eh.pc);
        chk({nm, ".instM"},       hd.inst, eh.inst);
        chk({nm, ".rdM"},         32'(hd.rd), 32'(eh.rd));
        chk({nm, ".resultM"},     hd.result, eh.result);
        chk({nm, ".store_dataM"}, hd.store_data, eh.store_data);
        chk({nm, ".mem_storeM"},  32'(hd.mem_store), 32'(eh.mem_store));
        chk({nm, ".mem_loadM"},   32'(hd.mem_load), 32'(eh.mem_load));
        chk({nm, ".reg_writeM"},  32'(hd.reg_write), 32'(eh.reg_write));
        chk({nm, ".fwd_we0"},     32'(w0), 32'(q.size() >= 1 && q[0].reg_write));
        chk({nm, ".fwd_we1"},     32'(w1), 32'(q.size() >= 2 && q[1].reg_write));
        if (q.size() >= 1) chk({nm, ".fwd_rd0"}, 32'(r0), 32'(q[0].rd));
        if (q.size() >= 2) chk({nm, ".fwd_rd1"}, 32'(r1), 32'(q[1].rd));
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input logic [RD_W-1:0] rd, input bit we);
        in_valid    = v;
        pcE         = pc;
        rdE         = rd;
        reg_writeE  = we;
        instE       = $urandom();
        resultE     = $urandom();
        store_dataE = $urandom();
        mem_storeE  = 2'($urandom_range(3));
        mem_loadE   = 3'($urandom_range(7));
    endtask

    // One clock: check outputs for current inputs, then advance both models at the edge.
    task automatic step(input bit do_chk);
        bit acc_a, con_a, acc_b, con_b;
        em_bundle_t nb;
        #1;
        if (do_chk) begin
            chk_inst("A", 1'b1, qa, a_in_ready, a_out_valid, a_hd, a_fwd_rd0, a_fwd_rd1, a_fwd_we0, a_fwd_we1, a_occ);
            chk_inst("B", 1'b0, qb, b_in_ready, b_out_valid, b_hd, b_fwd_rd0, b_fwd_rd1, b_fwd_we0, b_fwd_we1, b_occ);
        end
        nb    = {pcE, instE, rdE, resultE, store_dataE, mem_storeE, mem_loadE, reg_writeE};
        acc_a = in_valid && (qa.size() < 2);
        con_a = (qa.size() > 0) && out_ready;
        acc_b = in_valid && (qb.size() == 0 || out_ready);
        con_b = (qb.size() > 0) && out_ready;
        @(posedge CLK);
        if (!NRST || flush) begin
            qa.delete();
            qb.delete();
        end else begin
            if (con_a) void'(qa.pop_front());
            if (acc_a) qa.push_back(nb);
            if (con_b) void'(qb.pop_front());
            if (acc_b) qb.push_back(nb);
        end
        @(negedge CLK);
    endtask

    initial begin
        // Reset held two cycles with in_valid asserted
        NRST = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 32'h0000_0ABC, 5'd1, 1'b1);
        step(1'b0);
        step(1'b1);
        chk("rst.occ", 32'(a_occ), 32'd0);
        chk("rst.out_valid", 32'(a_out_valid), 32'd0);
        chk("rst.pcM", a_pcM, 32'd0);
        NRST = 1'b1;
        drive(1'b0, 32'd0, 5'd0, 1'b0);
        step(1'b1);

        // Streaming 0x100/0x104/0x108 with out_ready high
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 5'($urandom_range(31)), 1'($urandom_range(1)));
            step(1'b1);
            chk("stream.pcM", a_pcM, 32'h100 + 32'(4 * i));
            chk("stream.occ", 32'(a_occ), 32'd1);
            chk("stream.in_ready", 32'(a_in_ready), 32'd1);
        end
        drive(1'b0, 32'd0, 5'd0, 1'b0);
        step(1'b1);

        // Backpressure: two held entries, then drain in order
        out_ready = 1'b0;
        drive(1'b1, 32'h200, 5'd2, 1'b1);
        step(1'b1);
        drive(1'b1, 32'h204, 5'd4, 1'b1);
        step(1'b1);
        chk("bp.occ", 32'(a_occ), 32'd2);
        chk("bp.in_ready", 32'(a_in_ready), 32'd0);
        chk("bp.pcM", a_pcM, 32'h200);
        out_ready = 1'b1;
        drive(1'b0, 32'd0, 5'd0, 1'b0);
        step(1'b1);
        chk("bp.pcM2", a_pcM, 32'h204);
        chk("bp.in_ready2", 32'(a_in_ready), 32'd1);
        step(1'b1);
        chk("bp.occ_end", 32'(a_occ), 32'd0);

        // Flush with two entries held and an input offered
        out_ready = 1'b0;
        drive(1'b1, 32'h2F0, 5'd5, 1'b1);
        step(1'b1);
        drive(1'b1, 32'h2F4, 5'd5, 1'b1);
        step(1'b1);
        flush = 1'b1;
        drive(1'b1, 32'h300, 5'd5, 1'b1);
        step(1'b1);
        flush = 1'b0;
        drive(1'b0, 32'd0, 5'd0, 1'b0);
        chk("fl.occ", 32'(a_occ), 32'd0);
        chk("fl.out_valid", 32'(a_out_valid), 32'd0);
        chk("fl.we0", 32'(a_fwd_we0), 32'd0);
        chk("fl.we1", 32'(a_fwd_we1), 32'd0);
        chk("fl.reg_writeM", 32'(a_reg_writeM), 32'd0);
        out_ready = 1'b1;
        step(1'b1);
        step(1'b1);

        // Forwarding taps for main and skid entries
        out_ready = 1'b0;
        drive(1'b1, 32'h500, 5'd3, 1'b1);
        step(1'b1);
        drive(1'b1, 32'h504, 5'd7, 1'b1);
        step(1'b1);
        chk("fwd.rd0", 32'(a_fwd_rd0), 32'd3);
        chk("fwd.we0", 32'(a_fwd_we0), 32'd1);
        chk("fwd.rd1", 32'(a_fwd_rd1), 32'd7);
        chk("fwd.we1", 32'(a_fwd_we1), 32'd1);
        out_ready = 1'b1;
        drive(1'b0, 32'd0, 5'd0, 1'b0);
        step(1'b1);
        chk("fwd.rd0_after", 32'(a_fwd_rd0), 32'd7);
        chk("fwd.we1_after", 32'(a_fwd_we1), 32'd0);

        // Single-entry build: blocked, then pass-through
        flush = 1'b1;
        step(1'b1);
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 32'h400, 5'd9, 1'b0);
        step(1'b1);
        drive(1'b1, 32'h404, 5'd9, 1'b0);
        step(1'b1);
        out_ready = 1'b1;
        drive(1'b1, 32'h408, 5'd9, 1'b0);
        step(1'b1);
        chk("s0.pcM", b_pcM, 32'h408);
        chk("s0.occ", 32'(b_occ), 32'd1);
        chk("s0.a_pcM", a_pcM, 32'h404);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            NRST      = ($urandom_range(63) != 0);
            flush     = ($urandom_range(15) == 0);
            out_ready = 1'($urandom_range(1));
            drive($urandom_range(3) != 0, $urandom(), 5'($urandom_range(31)), 1'($urandom_range(1)));
            step(1'b1);
        end
        NRST = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 32'd0, 5'd0, 1'b0);
        step(1'b1);
        step(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
